pipeline_retire: RTL
====================

# pipeline_retire

Tail-end sink for the global-stall address pipeline: it captures entries leaving the last `pipeline_stage` into a small FIFO and hands them to a downstream consumer over a valid/ready handshake. It drives the global stall back to every stage so the FIFO never overflows. It also initiates ID-tagged flushes into the head of the pipeline and filters matching IDs until the flush reaches the tail.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `FLUSH_TIMEOUT`, 32: max cycles in FLUSHING before forced exit.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_address` in `ADDRESS_WIDTH`: address from last stage `out_address`.
- `in_id` in `ID_WIDTH`: ID from last stage.
- `in_valid` in 1: valid from last stage.
- `in_flush` in 1: flush pulse emerging from last stage `out_flush`.
- `in_flush_id` in `ID_WIDTH`: ID carried with `in_flush`.
- `kill_req` in 1: request to flush `kill_id`; level, held until acked.
- `kill_id` in `ID_WIDTH`: ID to kill.
- `kill_ack` out 1: one-cycle accept of `kill_req`.
- `out_flush` out 1: flush into first stage `in_flush`, one-cycle pulse.
- `out_flush_id` out `ID_WIDTH`: ID for `out_flush`.
- `out_stall` out 1: global stall to every stage `in_stall`.
- `out_address` out `ADDRESS_WIDTH`: FIFO head address.
- `out_id` out `ID_WIDTH`: FIFO head ID.
- `out_valid` out 1: head is live.
- `out_ready` in 1: consumer accepts head.
- `overflow` out 1: sticky, capture attempted while full.
- `flush_timeout` out 1: sticky, FLUSHING exited on timeout.

## Operation
- Reset: all outputs 0, FIFO empty, `stall_q` 0, state IDLE, all registers 0.
- Capture rule: `stall_q` holds the registered `out_stall` from the previous cycle. Capture when `in_valid && !stall_q`. A held, stalled stage output is captured exactly once.
- Drop rule: a capture is discarded, and never enters the FIFO, when state is FLUSHING and `in_id == kill_id_q`. It is also discarded in the accept cycle when `in_id == kill_id`.
- FIFO entry fields: `{address, id, live}`.
  - Push writes `live = 1`.
  - The pointers wrap modulo `DEPTH`.
  - Count ranges 0..`DEPTH`.
- Output handshake:
  - `out_valid` = count > 0 and head live; the head fields drive the outputs directly from registers.
  - The head pops when `out_valid && out_ready`.
  - A non-live head pops automatically with `out_valid = 0`.
  - Push and pop in the same cycle leave count unchanged.
- Stall: registered. `out_stall` is 1 after an edge iff post-edge count ≥ `DEPTH`−1. This leaves one slot for the single in-flight capture.
- Overflow: a capture with count == `DEPTH` and no pop is dropped and sets `overflow`.
- FSM states IDLE, FLUSHING:
  - IDLE with `kill_req`:
    - assert `kill_ack`;
    - register `kill_id_q`;
    - pulse `out_flush` / `out_flush_id` = `kill_id` on the next cycle;
    - clear `live` on every FIFO entry with matching ID;
    - go to FLUSHING and clear the timeout counter.
  - In FLUSHING, `kill_ack` = 0 and further requests wait.
  - FLUSHING → IDLE when `in_flush && in_flush_id == kill_id_q`.
  - FLUSHING → IDLE when the counter reaches `FLUSH_TIMEOUT`; this also sets `flush_timeout`.
  - The capture in the exit cycle still obeys the drop rule.
- Kill vs. pop in the same cycle: the pop completes and the entry is delivered; the kill applies to the remaining entries.
- `out_flush` is independent of `out_stall`, because stages propagate flush while stalled.

## Timing
- Capture to `out_valid`: 1 cycle. The capture is on edge N and `out_valid` is 1 in cycle N+1, given an empty FIFO.
- `kill_req` seen in cycle N: `kill_ack` is 1 in cycle N (combinational on IDLE). `out_flush` is 1 in cycle N+1 only.
- Stall assertion: set at the same edge as the push that brings count to `DEPTH`−1. Released at the edge where count drops below `DEPTH`−1.
- Reset mid-operation: the FIFO is emptied, FSM returns to IDLE, and sticky flags clear immediately (asynchronous).

## Test plan
- Streaming, DEPTH=4, `out_ready` = 1: IDs 1..6 at addresses 0x10..0x60, one per cycle. Each appears on `out_*` one cycle later, in order. `out_stall` stays 0.
- Backpressure, `out_ready` = 0, continuous input: `out_stall` rises at the edge that makes count 3. Count stops at exactly 4 and `overflow` stays 0. Releasing `out_ready` drains IDs in order with no duplicates.
- Held input under stall, `in_valid` = 1 with ID 7 held for 5 cycles while `stall_q` = 1: exactly one ID-7 entry is delivered.
- Kill in FIFO and in flight, FIFO holding IDs 2, 3, 2, `kill_req` ID 2:
  - `kill_ack` is 1 the same cycle and `out_flush` / `out_flush_id` = 1 / 2 the next cycle;
  - only ID 3 is delivered;
  - an ID-2 capture arriving before `in_flush` with `in_flush_id` = 2 is dropped.
- Flush timeout, FLUSH_TIMEOUT=32: kill ID 5 with `in_flush` never returning. After 32 cycles the FSM is in IDLE and `flush_timeout` = 1. A second `kill_req` is acked.
- Async reset during FLUSHING with 3 entries queued: all outputs 0 immediately and the FIFO is empty on release.

Source files
------------

// File: rtl/pipeline_retire.sv
// pipeline_retire
//   Tail-end sink for the global-stall address pipeline. Entries leaving the
//   last stage are captured into a small FIFO and handed to a downstream
//   consumer over valid/ready. The block drives the global stall so the FIFO
//   never overflows, launches ID-tagged flushes into the pipeline head, and
//   filters captures carrying the killed ID until the flush reaches the tail.
//
// Ports
//   clk, reset                    rising-edge clock, async active-high reset
//   in_address/in_id/in_valid     entry from the last stage
//   in_flush/in_flush_id          flush pulse emerging from the last stage
//   kill_req/kill_id/kill_ack     flush request (level) and one-cycle accept
//   out_flush/out_flush_id        flush pulse into the first stage
//   out_stall                     global stall to every stage
//   out_address/out_id/out_valid  FIFO head, out_ready pops it
//   overflow, flush_timeout       sticky error flags
module pipeline_retire #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int ID_WIDTH      = 4,
  parameter int DEPTH         = 4,
  parameter int FLUSH_TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  input  logic                     in_flush,
  input  logic [ID_WIDTH-1:0]      in_flush_id,
  input  logic                     kill_req,
  input  logic [ID_WIDTH-1:0]      kill_id,
  output logic                     kill_ack,
  output logic                     out_flush,
  output logic [ID_WIDTH-1:0]      out_flush_id,
  output logic                     out_stall,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     flush_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(FLUSH_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    FLUSHING = 1'b1
  } state_t;

  state_t state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [ID_WIDTH-1:0] kill_id_q;
  logic accept, timeout_hit;

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [ID_WIDTH-1:0]      id_mem   [DEPTH];
  logic [DEPTH-1:0]         live_mem;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count, count_next;

  // stall_reg is the registered out_stall; stall_q is that value one cycle
  // later. A stage that was still advancing when stall rose presents one more
  // entry while stall_q is 0, and that entry is captured exactly once.
  logic stall_reg, stall_q;
  logic flush_q;

  logic head_live, not_empty, full, pop, capture, drop_kill, push, overflow_hit;

  assign head_live   = live_mem[rd_ptr];
  assign not_empty   = (count != '0);
  assign full        = (count == FULL_LEVEL);
  assign out_valid   = not_empty && head_live;
  // A killed head leaves on its own, without waiting for the consumer.
  assign pop         = not_empty && (!head_live || out_ready);
  assign capture     = in_valid && !stall_q;
  assign drop_kill   = ((state == FLUSHING) && (in_id == kill_id_q)) ||
                       (accept && (in_id == kill_id));
  assign push        = capture && !drop_kill && (!full || pop);
  assign overflow_hit = capture && !drop_kill && full && !pop;

  assign out_address  = addr_mem[rd_ptr];
  assign out_id       = id_mem[rd_ptr];
  assign out_stall    = stall_reg;
  assign out_flush    = flush_q;
  assign out_flush_id = kill_id_q;
  assign kill_ack     = accept;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (kill_req) begin
          accept     = 1'b1;
          state_next = FLUSHING;
          timer_next = '0;
        end
      end
      FLUSHING: begin
        timer_next = timer + 1'b1;
        if (in_flush && (in_flush_id == kill_id_q)) begin
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      kill_id_q     <= '0;
      flush_q       <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      stall_reg     <= 1'b0;
      stall_q       <= 1'b0;
      overflow      <= 1'b0;
      flush_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      flush_q   <= accept;
      if (accept) kill_id_q <= kill_id;
      count     <= count_next;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      stall_reg <= (count_next >= STALL_LEVEL);
      stall_q   <= stall_reg;
      if (overflow_hit) overflow      <= 1'b1;
      if (timeout_hit)  flush_timeout <= 1'b1;
    end
  end

  // NOTE: the storage is reset as well so the head outputs read 0 out of
  // reset; at this depth the reset cost is negligible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        id_mem[i]   <= '0;
      end
      live_mem <= '0;
    end else begin
      // Clearing a slot that is popping this cycle, or one that is not
      // occupied, is harmless. The push below comes later, so its live=1 wins
      // on its own slot; its ID never matches an accepted kill_id anyway.
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (id_mem[i] == kill_id)) live_mem[i] <= 1'b0;
      end
      if (push) begin
        addr_mem[wr_ptr] <= in_address;
        id_mem[wr_ptr]   <= in_id;
        live_mem[wr_ptr] <= 1'b1;
      end
    end
  end

endmodule
